// File: rtl/multi_cycle_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state encoding,
// opcode constants, select encodings and the decoded control word.
// Optional feature macro used by the top level: MULTI_CYCLE_MEM_WAIT_EN.
package multi_cycle_pkg;

    localparam int OP_W    = 6;
    localparam int STATE_W = 4;

    // One state per instruction phase; 13-15 are unused encodings.
    typedef enum logic [STATE_W-1:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEM_ADDR = 4'd3,
        MEM_RD   = 4'd4,
        MEM_WB   = 4'd5,
        MEM_WR   = 4'd6,
        R_EXEC   = 4'd7,
        R_WB     = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        I_EXEC   = 4'd11,
        I_WB     = 4'd12
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [OP_W-1:0] OP_R    = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OP_W-1:0] OP_J    = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;

    // ALU operation select
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    // Full set of datapath controls produced for one state
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // True for the six opcodes this controller implements
    function automatic logic is_known_op(input logic [OP_W-1:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_outdec.sv
// Combinational state -> control word decoder for the multi-cycle controller.
// Pure Moore decode; memory-ready qualification is applied by the top level.
module multi_cycle_ctrl_outdec
    import multi_cycle_pkg::*;
(
    input  state_t i_state,
    output ctrl_t  o_ctrl
);

    // Map each phase to the enables and selects it needs; all else stays 0
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.ir_write  = 1'b1;
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.alu_src_b = SRC_B_FOUR;
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.pc_source = PCS_ALU;
            end
            DECODE: begin
                // Branch target computed speculatively into ALUOut
                o_ctrl.alu_src_b = SRC_B_IMM_SH;
            end
            MEM_ADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRC_B_IMM;
                o_ctrl.alu_op    = ALU_ADD;
            end
            MEM_RD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.i_or_d   = 1'b1;
            end
            MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.i_or_d    = 1'b1;
            end
            R_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRC_B_REG;
                o_ctrl.alu_op    = ALU_FUNCT;
            end
            R_WB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRC_B_REG;
                o_ctrl.alu_op        = ALU_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCS_ALUOUT;
            end
            JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCS_JUMP;
            end
            I_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRC_B_IMM;
                o_ctrl.alu_op    = ALU_ADD;
            end
            I_WB: begin
                o_ctrl.reg_write = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM: state register, next-state logic and
// memory-ready qualification; control word decoded by multi_cycle_ctrl_outdec.
// Optional macro MULTI_CYCLE_MEM_WAIT_EN adds memory wait states in
// FETCH, MEM_RD and MEM_WR.
module multi_cycle_ctrl
    import multi_cycle_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               ir_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               i_or_d,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    state_t r_state;
    ctrl_t  w_ctrl;
    logic   w_ready;
    logic   w_fetch_hold;

`ifdef MULTI_CYCLE_MEM_WAIT_EN
    assign w_ready = mem_ready;
`else
    // Every memory access completes in one cycle; mem_ready has no effect
    assign w_ready = mem_ready | 1'b1;
`endif

    // While FETCH waits on memory, PC and IR must not load
    assign w_fetch_hold = (r_state == FETCH) && !w_ready;

    // Phase sequencing: one phase per clock, memory phases may stretch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:     r_state <= FETCH;
                FETCH:    if (w_ready) r_state <= DECODE;
                DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: r_state <= MEM_ADDR;
                        OP_R:         r_state <= R_EXEC;
                        OP_BEQ:       r_state <= BRANCH;
                        OP_J:         r_state <= JUMP;
                        OP_ADDI:      r_state <= I_EXEC;
                        default:      r_state <= FETCH;
                    endcase
                end
                MEM_ADDR: begin
                    if (opcode == OP_LW)      r_state <= MEM_RD;
                    else if (opcode == OP_SW) r_state <= MEM_WR;
                    else                      r_state <= FETCH;
                end
                MEM_RD:   if (w_ready) r_state <= MEM_WB;
                MEM_WB:   r_state <= FETCH;
                MEM_WR:   if (w_ready) r_state <= FETCH;
                R_EXEC:   r_state <= R_WB;
                R_WB:     r_state <= FETCH;
                BRANCH:   r_state <= FETCH;
                JUMP:     r_state <= FETCH;
                I_EXEC:   r_state <= I_WB;
                I_WB:     r_state <= FETCH;
                default:  r_state <= FETCH;
            endcase
        end
    end

    multi_cycle_ctrl_outdec u_outdec (
        .i_state (r_state),
        .o_ctrl  (w_ctrl)
    );

    assign pc_write      = w_ctrl.pc_write & ~w_fetch_hold;
    assign ir_write      = w_ctrl.ir_write & ~w_fetch_hold;
    assign pc_write_cond = w_ctrl.pc_write_cond;
    assign mem_read      = w_ctrl.mem_read;
    assign mem_write     = w_ctrl.mem_write;
    assign i_or_d        = w_ctrl.i_or_d;
    assign reg_write     = w_ctrl.reg_write;
    assign reg_dst       = w_ctrl.reg_dst;
    assign mem_to_reg    = w_ctrl.mem_to_reg;
    assign alu_src_a     = w_ctrl.alu_src_a;
    assign alu_src_b     = w_ctrl.alu_src_b;
    assign alu_op        = w_ctrl.alu_op;
    assign pc_source     = w_ctrl.pc_source;
    assign illegal_op    = (r_state == DECODE) && !is_known_op(opcode);
    assign state         = r_state;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: directed instructions, random
// instruction mix, memory wait states (when MULTI_CYCLE_MEM_WAIT_EN is
// defined) and asynchronous reset in the middle of a store.
module tb_multi_cycle_ctrl;

`ifdef MULTI_CYCLE_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    multi_cycle_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ir_write      (ir_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .i_or_d        (i_or_d),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    always #5 clk = ~clk;

    logic [16:0] outs;
    assign outs = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d,
                   reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                   pc_source, illegal_op};

    function automatic bit known_op(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
               op == 6'b000100 || op == 6'b000010 || op == 6'b001000;
    endfunction

    // Expected outputs straight from the phase table
    function automatic logic [16:0] exp_ctrl(input int st, input bit rdy, input bit ill);
        logic pw, pwc, irw, mr, mw, iod, rw, rd, m2r, sa, il;
        logic [1:0] sb, ao, ps;
        bit go;
        go = WAIT_EN ? rdy : 1'b1;
        {pw, pwc, irw, mr, mw, iod, rw, rd, m2r, sa, il} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (st)
            1:  begin mr = 1; irw = go; pw = go; sb = 2'b01; end
            2:  begin sb = 2'b11; il = ill; end
            3:  begin sa = 1; sb = 2'b10; end
            4:  begin mr = 1; iod = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mw = 1; iod = 1; end
            7:  begin sa = 1; ao = 2'b10; end
            8:  begin rw = 1; rd = 1; end
            9:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
            10: begin pw = 1; ps = 2'b10; end
            11: begin sa = 1; sb = 2'b10; end
            12: begin rw = 1; end
            default: ;
        endcase
        return {pw, pwc, irw, mr, mw, iod, rw, rd, m2r, sa, sb, ao, ps, il};
    endfunction

    task automatic check_now(input int exp_st, input bit rdy, input bit ill, input string tag);
        logic [3:0]  es;
        logic [16:0] eo;
        es = 4'(exp_st);
        eo = exp_ctrl(exp_st, rdy, ill);
        checks++;
        assert (state === es) else begin
            errors++;
            $error("FAIL %s state got %0d want %0d", tag, state, es);
        end
        checks++;
        assert (outs === eo) else begin
            errors++;
            $error("FAIL %s outputs in state %0d got %b want %b", tag, exp_st, outs, eo);
        end
    endtask

    // Drive one cycle's inputs away from the active edge, then check
    task automatic step(input int exp_st, input bit rst, input bit rdy,
                        input logic [5:0] op, input bit ill, input string tag);
        @(negedge clk);
        rst_n     = rst;
        mem_ready = rdy;
        opcode    = op;
        #1;
        check_now(exp_st, rdy, ill, tag);
    endtask

    // Run one instruction through its phase list; stop early at stop_at
    task automatic run_instr(input logic [5:0] op, input int fetch_wait, input int stop_at,
                             input string tag);
        int seq[$];
        int cycles;
        bit ill;
        ill = !known_op(op);
        case (op)
            6'b100011: seq = '{1, 2, 3, 4, 5};
            6'b101011: seq = '{1, 2, 3, 6};
            6'b000000: seq = '{1, 2, 7, 8};
            6'b000100: seq = '{1, 2, 9};
            6'b000010: seq = '{1, 2, 10};
            6'b001000: seq = '{1, 2, 11, 12};
            default:   seq = '{1, 2};
        endcase
        cycles = 0;
        foreach (seq[i]) begin
            int  p;
            int  w;
            bit  rdy;
            logic [5:0] dop;
            p = seq[i];
            w = 0;
            if (WAIT_EN && (p == 1 || p == 4 || p == 6))
                w = (p == 1 && fetch_wait >= 0) ? fetch_wait : int'($urandom_range(0, 2));
            for (int k = 0; k <= w; k++) begin
                rdy = WAIT_EN ? (k == w) : 1'($urandom_range(0, 1));
                dop = (p == 2 || p == 3) ? op : 6'($urandom);
                step(p, 1'b1, rdy, dop, ill && (p == 2), tag);
                cycles++;
                if (p == stop_at) return;
            end
        end
        $display("instr %s op=%b cycles=%0d", tag, op, cycles);
    endtask

    logic [5:0] legal_ops [6] = '{6'b000000, 6'b100011, 6'b101011,
                                  6'b000100, 6'b000010, 6'b001000};

    initial begin
        logic [5:0] rop;
        rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'b0;

        // Reset held for three clocks, then one IDLE cycle after release
        for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b1, 6'($urandom), 1'b0, "reset");
        step(0, 1'b1, 1'b1, 6'($urandom), 1'b0, "idle_after_reset");

        // Directed instructions
        run_instr(6'b100011, -1, -1, "LW");
        run_instr(6'b000000, -1, -1, "R");
        run_instr(6'b000100, -1, -1, "BEQ");
        run_instr(6'b111111, -1, -1, "ILLEGAL");
        run_instr(6'b101011, -1, -1, "SW");
        run_instr(6'b000010, -1, -1, "J");
        run_instr(6'b001000, -1, -1, "ADDI");
        run_instr(6'b100011, 3, -1, "LW_fetch_wait3");

        // Random instruction mix including unknown opcodes
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 6) == 6) begin
                do rop = 6'($urandom); while (known_op(rop));
            end else begin
                rop = legal_ops[$urandom_range(0, 5)];
            end
            run_instr(rop, -1, -1, "random");
        end

        // Asynchronous reset while in MEM_WR
        run_instr(6'b101011, -1, 6, "SW_to_MEM_WR");
        #2;
        rst_n = 1'b0;
        #1;
        check_now(0, 1'b1, 1'b0, "async_reset_in_MEM_WR");
        step(0, 1'b0, 1'b1, 6'($urandom), 1'b0, "reset_hold");
        step(0, 1'b1, 1'b1, 6'($urandom), 1'b0, "idle_after_midreset");
        run_instr(6'b000000, -1, -1, "R_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

endmodule
